// File: rtl/pcie_buf_scheduler_if.sv
// Host/engine signal bundle for the ping-pong buffer scheduler.
// master = host/engine side, slave = scheduler side.
interface pcie_buf_scheduler_if;
  logic        i_cmd_stb;
  logic [31:0] i_cmd_data_count;
  logic        i_cmd_rst_stb;
  logic        i_update_buf_stb;
  logic [1:0]  i_update_buf;
  logic [31:0] i_buffer_size;
  logic [31:0] i_buf_a_addr;
  logic [31:0] i_buf_b_addr;
  logic        o_req;
  logic [31:0] o_req_addr;
  logic [31:0] o_req_len;
  logic        i_req_ack;
  logic        i_req_done;
  logic        o_buf_sel;
  logic        o_buf_done_stb;
  logic [1:0]  o_buf_done;
  logic        o_xfer_done;
  logic        o_error;
  logic        o_busy;
  logic [2:0]  o_state;

  modport master (
    output i_cmd_stb, i_cmd_data_count, i_cmd_rst_stb, i_update_buf_stb, i_update_buf,
           i_buffer_size, i_buf_a_addr, i_buf_b_addr, i_req_ack, i_req_done,
    input  o_req, o_req_addr, o_req_len, o_buf_sel, o_buf_done_stb, o_buf_done,
           o_xfer_done, o_error, o_busy, o_state
  );

  modport slave (
    input  i_cmd_stb, i_cmd_data_count, i_cmd_rst_stb, i_update_buf_stb, i_update_buf,
           i_buffer_size, i_buf_a_addr, i_buf_b_addr, i_req_ack, i_req_done,
    output o_req, o_req_addr, o_req_len, o_buf_sel, o_buf_done_stb, o_buf_done,
           o_xfer_done, o_error, o_busy, o_state
  );
endinterface

// File: rtl/pcie_buf_scheduler.sv
// Splits a host transfer into buffer-sized DMA requests, alternating strictly
// between host buffers A and B as the host marks each one ready.
module pcie_buf_scheduler #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic                  clk,
  input logic                  rst,
  pcie_buf_scheduler_if.slave  bus
);
  typedef enum logic [2:0] {IDLE = 3'd0, WAIT_BUF = 3'd1, REQ = 3'd2, XFER = 3'd3, NEXT = 3'd4} state_t;

  state_t      state, state_nxt;
  logic [1:0]  ready, set_mask, clr_mask, ptr_hot;
  logic [31:0] remaining, rem_after, req_addr, req_len, next_len, tmo_cnt;
  logic        ptr, tmo_hit, size_err, abort, xfer_done, error;

  assign ptr_hot   = ptr ? 2'b10 : 2'b01;
  assign rem_after = remaining - req_len;
  assign next_len  = (remaining < bus.i_buffer_size) ? remaining : bus.i_buffer_size;
  assign set_mask  = bus.i_update_buf_stb ? bus.i_update_buf : 2'b00;
  assign clr_mask  = (state == NEXT) ? ptr_hot : 2'b00;
  assign abort     = bus.i_cmd_rst_stb | tmo_hit | size_err;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tmo_hit   = 1'b0;
    size_err  = 1'b0;
    if (bus.i_cmd_rst_stb) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:     if (bus.i_cmd_stb && bus.i_cmd_data_count != 32'd0) state_nxt = WAIT_BUF;
        WAIT_BUF: if (ready[ptr]) begin
                    if (bus.i_buffer_size == 32'd0) begin
                      size_err  = 1'b1;
                      state_nxt = IDLE;
                    end else begin
                      state_nxt = REQ;
                    end
                  end
        REQ:      if (bus.i_req_ack) state_nxt = XFER;
        // done on the last allowed cycle still counts as a completion
        XFER:     if (bus.i_req_done) state_nxt = NEXT;
                  else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                  end
        NEXT:     state_nxt = (rem_after == 32'd0) ? IDLE : WAIT_BUF;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_req          = (state == REQ);
    bus.o_busy         = (state != IDLE);
    bus.o_buf_done_stb = (state == NEXT);
    bus.o_buf_done     = (state == NEXT) ? ptr_hot : 2'b00;
    bus.o_state        = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready     <= 2'b00;
      remaining <= 32'd0;
      ptr       <= 1'b0;
      tmo_cnt   <= 32'd0;
      req_addr  <= 32'd0;
      req_len   <= 32'd0;
      xfer_done <= 1'b0;
      error     <= 1'b0;
    end else begin
      xfer_done <= 1'b0;
      error     <= tmo_hit | size_err;
      tmo_cnt   <= (state == XFER && state_nxt == XFER) ? tmo_cnt + 32'd1 : 32'd0;
      if (abort) begin
        ready     <= 2'b00;
        remaining <= 32'd0;
        ptr       <= 1'b0;
      end else begin
        // a host strobe landing on the consuming cycle keeps the bit set
        ready <= (ready & ~clr_mask) | set_mask;
        case (state)
          IDLE: if (bus.i_cmd_stb) begin
                  remaining <= bus.i_cmd_data_count;
                  ptr       <= 1'b0;
                  xfer_done <= (bus.i_cmd_data_count == 32'd0);
                end
          WAIT_BUF: if (state_nxt == REQ) begin
                      req_addr <= ptr ? bus.i_buf_b_addr : bus.i_buf_a_addr;
                      req_len  <= next_len;
                    end
          NEXT: begin
                  remaining <= rem_after;
                  ptr       <= ~ptr;
                  xfer_done <= (rem_after == 32'd0);
                end
          default: ;
        endcase
      end
    end
  end

  assign bus.o_req_addr  = req_addr;
  assign bus.o_req_len   = req_len;
  assign bus.o_buf_sel   = ptr;
  assign bus.o_xfer_done = xfer_done;
  assign bus.o_error     = error;
endmodule

// File: tb/tb_pcie_buf_scheduler.sv
// Directed and randomized checks of pcie_buf_scheduler against expected
// request sequences computed from the transfer/buffer arithmetic.
module tb_pcie_buf_scheduler;
  localparam int TMO = 16;
  localparam logic [31:0] ADDR_A = 32'h1000_0000;
  localparam logic [31:0] ADDR_B = 32'h2000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0, n_pass = 0, n_fail = 0;

  pcie_buf_scheduler_if bus();
  pcie_buf_scheduler #(.TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cmd(input logic [31:0] cnt);
    bus.i_cmd_stb = 1'b1; bus.i_cmd_data_count = cnt;
    tick();
    bus.i_cmd_stb = 1'b0;
  endtask

  task automatic upd(input logic [1:0] mask);
    bus.i_update_buf_stb = 1'b1; bus.i_update_buf = mask;
    tick();
    bus.i_update_buf_stb = 1'b0;
  endtask

  task automatic kill();
    bus.i_cmd_rst_stb = 1'b1;
    tick();
    bus.i_cmd_rst_stb = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (bus.o_req !== 1'b1 && n < 64) begin tick(); n++; end
    chk({tag, "_req_seen"}, 32'(bus.o_req), 32'd1);
  endtask

  // Handles one request end to end; returns one cycle after the NEXT cycle.
  task automatic serve(input string tag, input logic [31:0] ea, input logic [31:0] el,
                       input logic es, input logic last, input logic [1:0] nupd);
    int d;
    wait_req(tag);
    chk({tag, "_addr"}, bus.o_req_addr, ea);
    chk({tag, "_len"}, bus.o_req_len, el);
    chk({tag, "_sel"}, 32'(bus.o_buf_sel), 32'(es));
    d = $urandom_range(1, 3);
    repeat (d) tick();
    chk({tag, "_hold_req"}, 32'(bus.o_req), 32'd1);
    chk({tag, "_hold_addr"}, bus.o_req_addr, ea);
    chk({tag, "_hold_len"}, bus.o_req_len, el);
    bus.i_req_ack = 1'b1;
    tick();
    bus.i_req_ack = 1'b0;
    chk({tag, "_ack_drop"}, 32'(bus.o_req), 32'd0);
    chk({tag, "_xfer_state"}, 32'(bus.o_state), 32'd3);
    d = $urandom_range(0, TMO - 6);
    repeat (d) tick();
    bus.i_req_done = 1'b1;
    tick();
    bus.i_req_done = 1'b0;
    chk({tag, "_next_state"}, 32'(bus.o_state), 32'd4);
    chk({tag, "_done_stb"}, 32'(bus.o_buf_done_stb), 32'd1);
    chk({tag, "_done_mask"}, 32'(bus.o_buf_done), es ? 32'd2 : 32'd1);
    if (nupd != 2'b00) begin
      bus.i_update_buf_stb = 1'b1; bus.i_update_buf = nupd;
    end
    tick();
    bus.i_update_buf_stb = 1'b0;
    chk({tag, "_xfer_done"}, 32'(bus.o_xfer_done), 32'(last));
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'(!last));
    chk({tag, "_stb_end"}, 32'(bus.o_buf_done_stb), 32'd0);
  endtask

  initial begin
    logic [31:0] bs, cnt, rem, len, a, b;
    logic        p;
    int          guard;
    bus.i_cmd_stb = 0; bus.i_cmd_data_count = 0; bus.i_cmd_rst_stb = 0;
    bus.i_update_buf_stb = 0; bus.i_update_buf = 0; bus.i_buffer_size = 256;
    bus.i_buf_a_addr = ADDR_A; bus.i_buf_b_addr = ADDR_B;
    bus.i_req_ack = 0; bus.i_req_done = 0;

    // reset state
    repeat (3) tick();
    chk("rst_state", 32'(bus.o_state), 32'd0);
    chk("rst_req", 32'(bus.o_req), 32'd0);
    chk("rst_addr", bus.o_req_addr, 32'd0);
    chk("rst_len", bus.o_req_len, 32'd0);
    chk("rst_sel", 32'(bus.o_buf_sel), 32'd0);
    chk("rst_done_stb", 32'(bus.o_buf_done_stb), 32'd0);
    chk("rst_done", 32'(bus.o_buf_done), 32'd0);
    chk("rst_xfer", 32'(bus.o_xfer_done), 32'd0);
    chk("rst_err", 32'(bus.o_error), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    rst = 1'b0;
    tick();

    // 600 dwords over 256-dword buffers
    upd(2'b11);
    cmd(32'd600);
    serve("s1a", ADDR_A, 32'd256, 1'b0, 1'b0, 2'b00);
    upd(2'b01);
    serve("s1b", ADDR_B, 32'd256, 1'b1, 1'b0, 2'b00);
    serve("s1c", ADDR_A, 32'd88, 1'b0, 1'b1, 2'b00);
    chk("s1_state_idle", 32'(bus.o_state), 32'd0);
    tick();
    chk("s1_single_done", 32'(bus.o_xfer_done), 32'd0);

    // only B ready: stall on A, then A releases the request
    kill();
    upd(2'b10);
    cmd(32'd100);
    repeat (5) tick();
    chk("s2_no_req", 32'(bus.o_req), 32'd0);
    chk("s2_wait_state", 32'(bus.o_state), 32'd1);
    upd(2'b01);
    wait_req("s2");
    chk("s2_addr", bus.o_req_addr, ADDR_A);
    chk("s2_len", bus.o_req_len, 32'd100);
    // abort while requesting; ready must be wiped
    kill();
    chk("s3_req_drop", 32'(bus.o_req), 32'd0);
    chk("s3_state", 32'(bus.o_state), 32'd0);
    cmd(32'd100);
    repeat (4) tick();
    chk("s3_ready_cleared", 32'(bus.o_req), 32'd0);
    kill();

    // host re-marks A on the very cycle A is consumed
    upd(2'b11);
    cmd(32'd512);
    serve("s4a", ADDR_A, 32'd256, 1'b0, 1'b0, 2'b01);
    serve("s4b", ADDR_B, 32'd256, 1'b1, 1'b1, 2'b00);
    cmd(32'd10);
    serve("s4c", ADDR_A, 32'd10, 1'b0, 1'b1, 2'b00);

    // withheld completion
    upd(2'b01);
    cmd(32'd50);
    wait_req("s5");
    bus.i_req_ack = 1'b1;
    tick();
    bus.i_req_ack = 1'b0;
    repeat (TMO - 1) tick();
    chk("s5_still_xfer", 32'(bus.o_state), 32'd3);
    chk("s5_no_err_yet", 32'(bus.o_error), 32'd0);
    tick();
    chk("s5_state", 32'(bus.o_state), 32'd0);
    chk("s5_err", 32'(bus.o_error), 32'd1);
    chk("s5_req", 32'(bus.o_req), 32'd0);
    tick();
    chk("s5_err_pulse", 32'(bus.o_error), 32'd0);

    // zero count and zero buffer size
    cmd(32'd0);
    chk("s6_done", 32'(bus.o_xfer_done), 32'd1);
    chk("s6_idle", 32'(bus.o_state), 32'd0);
    tick();
    chk("s6_done_pulse", 32'(bus.o_xfer_done), 32'd0);
    chk("s6_no_req", 32'(bus.o_req), 32'd0);
    bus.i_buffer_size = 32'd0;
    upd(2'b01);
    cmd(32'd10);
    chk("s7_wait", 32'(bus.o_state), 32'd1);
    tick();
    chk("s7_err", 32'(bus.o_error), 32'd1);
    chk("s7_idle", 32'(bus.o_state), 32'd0);
    chk("s7_no_req", 32'(bus.o_req), 32'd0);

    // randomized transfers against the split-into-buffers model
    for (int t = 0; t < 6; t++) begin
      bs = 32'($urandom_range(16, 64));
      a = $urandom; b = $urandom;
      cnt = 32'($urandom_range(1, 300));
      bus.i_buffer_size = bs; bus.i_buf_a_addr = a; bus.i_buf_b_addr = b;
      kill();
      cmd(cnt);
      rem = cnt; p = 1'b0; guard = 0;
      while (rem != 0 && guard < 40) begin
        len = (rem < bs) ? rem : bs;
        repeat ($urandom_range(0, 2)) tick();
        upd(p ? 2'b10 : 2'b01);
        serve($sformatf("r%0d_%0d", t, guard), p ? b : a, len, p, rem == len, 2'b00);
        rem = rem - len; p = ~p; guard++;
      end
      chk($sformatf("r%0d_idle", t), 32'(bus.o_state), 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
